// File: rtl/vga_pkg.sv
// Shared VGA timing constants, colours and a rectangle hit-test helper
// for the battery gauge display.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_TOTAL  = 800;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_TOTAL  = 525;

    localparam int CNT_W = 10;

    localparam logic [11:0] C_WHITE  = 12'hFFF;
    localparam logic [11:0] C_RED    = 12'hF00;
    localparam logic [11:0] C_YELLOW = 12'hFF0;
    localparam logic [11:0] C_GREEN  = 12'h0F0;
    localparam logic [11:0] C_DARK   = 12'h222;
    localparam logic [11:0] C_BLACK  = 12'h000;

    function automatic logic in_rect(
        input logic [31:0] x,
        input logic [31:0] y,
        input int          x0,
        input int          y0,
        input int          w,
        input int          h
    );
        return (x >= 32'(x0)) && (x < 32'(x0 + w)) &&
               (y >= 32'(y0)) && (y < 32'(y0 + h));
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel-rate divider, horizontal/vertical counters and the combinational
// sync / active-area decode derived from them.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int H_ACT    = H_ACTIVE,
    parameter int H_FRONT  = H_FP,
    parameter int H_SW     = H_SYNC,
    parameter int H_TOT    = H_TOTAL,
    parameter int V_ACT    = V_ACTIVE,
    parameter int V_FRONT  = V_FP,
    parameter int V_SW     = V_SYNC,
    parameter int V_TOT    = V_TOTAL
) (
    input  logic             clk1,
    input  logic             rst,
    output logic             pix_en,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             hsync_raw,
    output logic             vsync_raw,
    output logic             active
);

    logic [3:0]       div_q, div_d;
    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] v_q, v_d;

    always_comb begin
        pix_en = (div_q == 4'(CLK_DIV - 1));
        div_d  = pix_en ? 4'd0 : div_q + 4'd1;
        h_d    = h_q;
        v_d    = v_q;
        if (pix_en) begin
            if (h_q == CNT_W'(H_TOT - 1)) begin
                h_d = '0;
                if (v_q == CNT_W'(V_TOT - 1)) begin
                    v_d = '0;
                end else begin
                    v_d = v_q + CNT_W'(1);
                end
            end else begin
                h_d = h_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            div_q <= '0;
            h_q   <= '0;
            v_q   <= '0;
        end else begin
            div_q <= div_d;
            h_q   <= h_d;
            v_q   <= v_d;
        end
    end

    always_comb begin
        h_cnt     = h_q;
        v_cnt     = v_q;
        hsync_raw = !((h_q >= CNT_W'(H_ACT + H_FRONT)) &&
                      (h_q <  CNT_W'(H_ACT + H_FRONT + H_SW)));
        vsync_raw = !((v_q >= CNT_W'(V_ACT + V_FRONT)) &&
                      (v_q <  CNT_W'(V_ACT + V_FRONT + V_SW)));
        active    = (h_q < CNT_W'(H_ACT)) && (v_q < CNT_W'(V_ACT));
    end

endmodule

// File: rtl/vga_battery_display.sv
// Battery gauge renderer: latches bat_ctl once per frame at the start of
// vertical blanking and draws a blinking, colour-coded fill bar.
module vga_battery_display
    import vga_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int BOX_X      = 184,
    parameter int BOX_Y      = 220,
    parameter int LOW_THRESH = 8,
    parameter int MID_THRESH = 16,
    parameter int BLINK_LOG2 = 4,
    parameter int H_ACT      = H_ACTIVE,
    parameter int H_FRONT    = H_FP,
    parameter int H_SW       = H_SYNC,
    parameter int H_TOT      = H_TOTAL,
    parameter int V_ACT      = V_ACTIVE,
    parameter int V_FRONT    = V_FP,
    parameter int V_SW       = V_SYNC,
    parameter int V_TOT      = V_TOTAL
) (
    input  logic       clk1,
    input  logic       rst,
    input  logic [4:0] bat_ctl,
    output logic       hsync,
    output logic       vsync,
    output logic [3:0] vga_r,
    output logic [3:0] vga_g,
    output logic [3:0] vga_b,
    output logic       frame_start
);

    localparam int FW = BLINK_LOG2 + 1;

    logic             pix_en, hsync_raw, vsync_raw, active;
    logic [CNT_W-1:0] h_cnt, v_cnt;

    vga_timing_gen #(
        .CLK_DIV (CLK_DIV),
        .H_ACT   (H_ACT),
        .H_FRONT (H_FRONT),
        .H_SW    (H_SW),
        .H_TOT   (H_TOT),
        .V_ACT   (V_ACT),
        .V_FRONT (V_FRONT),
        .V_SW    (V_SW),
        .V_TOT   (V_TOT)
    ) u_timing (
        .clk1      (clk1),
        .rst       (rst),
        .pix_en    (pix_en),
        .h_cnt     (h_cnt),
        .v_cnt     (v_cnt),
        .hsync_raw (hsync_raw),
        .vsync_raw (vsync_raw),
        .active    (active)
    );

    logic [4:0]    level_q, level_d;
    logic [FW-1:0] frame_cnt_q, frame_cnt_d;
    logic          frame_start_q, frame_start_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic [11:0]   rgb_q, rgb_d;

    logic          latch, blink_on, is_low, is_mid;
    logic          outline, nub, interior;
    logic [7:0]    fill_w;
    logic [31:0]   x, y, xr;
    logic [11:0]   edge_col, fill_col, colour;

    always_comb begin
        latch         = pix_en && (h_cnt == '0) && (v_cnt == CNT_W'(V_ACT));
        level_d       = latch ? bat_ctl : level_q;
        frame_cnt_d   = latch ? frame_cnt_q + FW'(1) : frame_cnt_q;
        frame_start_d = latch;
        hsync_d       = hsync_raw;
        vsync_d       = vsync_raw;

        x        = 32'(h_cnt);
        y        = 32'(v_cnt);
        xr       = x - 32'(BOX_X + 4);
        fill_w   = {level_q, 3'b000};
        blink_on = frame_cnt_q[BLINK_LOG2];
        is_low   = 32'(level_q) < LOW_THRESH;
        is_mid   = !is_low && (32'(level_q) < MID_THRESH);

        outline  = in_rect(x, y, BOX_X, BOX_Y, 264, 40) &&
                   !in_rect(x, y, BOX_X + 2, BOX_Y + 2, 260, 36);
        nub      = in_rect(x, y, BOX_X + 264, BOX_Y + 12, 4, 16);
        interior = in_rect(x, y, BOX_X + 4, BOX_Y + 4, 256, 32);

        // An empty battery flashes its whole outline red
        edge_col = ((level_q == '0) && !blink_on) ? C_RED : C_WHITE;

        unique case (1'b1)
            is_low:  fill_col = blink_on ? C_RED : C_DARK;
            is_mid:  fill_col = C_YELLOW;
            default: fill_col = C_GREEN;
        endcase

        colour = C_BLACK;
        if (outline || nub) begin
            colour = edge_col;
        end else if (interior) begin
            colour = (xr < 32'(fill_w)) ? fill_col : C_DARK;
        end
        rgb_d = active ? colour : C_BLACK;
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            level_q       <= '0;
            frame_cnt_q   <= '0;
            frame_start_q <= 1'b0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            rgb_q         <= '0;
        end else begin
            level_q       <= level_d;
            frame_cnt_q   <= frame_cnt_d;
            frame_start_q <= frame_start_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            rgb_q         <= rgb_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign vga_r       = rgb_q[11:8];
    assign vga_g       = rgb_q[7:4];
    assign vga_b       = rgb_q[3:0];
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_battery_display.sv
// Directed bench: a shrunken-frame instance for rendering/latch/blink and a
// default 640x480 instance for line timing with the /4 pixel divider.
module tb_vga_battery_display;

    localparam int HT = 288;
    localparam int VT = 46;
    localparam int FR = HT * VT;

    logic       clk1 = 1'b0;
    logic       rst  = 1'b1;
    logic [4:0] bat_ctl = 5'd0;

    logic       hsync, vsync, frame_start;
    logic [3:0] vga_r, vga_g, vga_b;
    logic       f_hsync, f_vsync, f_frame_start;
    logic [3:0] f_r, f_g, f_b;
    logic [11:0] rgb, f_rgb;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    assign rgb   = {vga_r, vga_g, vga_b};
    assign f_rgb = {f_r, f_g, f_b};

    vga_battery_display #(
        .CLK_DIV    (1),
        .BOX_X      (2),
        .BOX_Y      (1),
        .BLINK_LOG2 (0),
        .H_ACT      (272),
        .H_FRONT    (4),
        .H_SW       (8),
        .H_TOT      (HT),
        .V_ACT      (42),
        .V_FRONT    (1),
        .V_SW       (2),
        .V_TOT      (VT)
    ) dut (
        .clk1        (clk1),
        .rst         (rst),
        .bat_ctl     (bat_ctl),
        .hsync       (hsync),
        .vsync       (vsync),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .frame_start (frame_start)
    );

    vga_battery_display dut_full (
        .clk1        (clk1),
        .rst         (rst),
        .bat_ctl     (bat_ctl),
        .hsync       (f_hsync),
        .vsync       (f_vsync),
        .vga_r       (f_r),
        .vga_g       (f_g),
        .vga_b       (f_b),
        .frame_start (f_frame_start)
    );

    always #5 clk1 = ~clk1;

    always @(posedge clk1) cyc <= rst ? 0 : cyc + 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic at_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk1);
            #1;
        end
    endtask

    task automatic go(input int f, input int x, input int y);
        at_cyc(f * FR + y * HT + x + 1);
    endtask

    task automatic px(input string tag, input int f, input int x,
                      input int y, input logic [11:0] exp);
        go(f, x, y);
        check(tag, 32'(rgb), 32'(exp));
    endtask

    task automatic reset_vals(input string tag);
        check({tag, "_hs"}, 32'(hsync), 32'd1);
        check({tag, "_vs"}, 32'(vsync), 32'd1);
        check({tag, "_rgb"}, 32'(rgb), 32'h000);
        check({tag, "_fs"}, 32'(frame_start), 32'd0);
        check({tag, "_full_hs"}, 32'(f_hsync), 32'd1);
        check({tag, "_full_rgb"}, 32'(f_rgb), 32'h000);
    endtask

    task automatic restart_timing(input string tag);
        go(0, 275, 0);
        check({tag, "_hs_pre"}, 32'(hsync), 32'd1);
        go(0, 276, 0);
        check({tag, "_hs_fall"}, 32'(hsync), 32'd0);
        px({tag, "_edge_red"}, 0, 2, 1, 12'hF00);
        at_cyc(2624);
        check({tag, "_full_hs_pre"}, 32'(f_hsync), 32'd1);
        at_cyc(2625);
        check({tag, "_full_hs_fall"}, 32'(f_hsync), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk1);
        #1;
        reset_vals("reset");
        rst = 1'b0;

        // frame 0: level 0, blink off
        px("f0_bg", 0, 0, 0, 12'h000);
        restart_timing("f0");
        check("f0_full_rgb_blank", 32'(f_rgb), 32'h000);
        at_cyc(3008);
        check("full_hs_low_end", 32'(f_hsync), 32'd0);
        at_cyc(3009);
        check("full_hs_rise", 32'(f_hsync), 32'd1);
        check("full_vs", 32'(f_vsync), 32'd1);
        at_cyc(5824);
        check("full_hs_p2_pre", 32'(f_hsync), 32'd1);
        at_cyc(5825);
        check("full_hs_p2_fall", 32'(f_hsync), 32'd0);
        px("f0_empty_fill", 0, 6, 21, 12'h222);
        go(0, 0, 30);
        bat_ctl = 5'd16;
        at_cyc(12096);
        check("fs_before", 32'(frame_start), 32'd0);
        at_cyc(12097);
        check("fs_pulse", 32'(frame_start), 32'd1);
        check("vs_v42", 32'(vsync), 32'd1);
        at_cyc(12098);
        check("fs_after", 32'(frame_start), 32'd0);
        go(0, 0, 43);
        check("vs_v43", 32'(vsync), 32'd0);
        go(0, 0, 44);
        check("vs_v44", 32'(vsync), 32'd0);
        go(0, 0, 45);
        check("vs_v45", 32'(vsync), 32'd1);

        // frame 1: level 16, green; mid-frame change must not show
        px("f1_edge_white", 1, 2, 1, 12'hFFF);
        px("f1_nub_above", 1, 266, 12, 12'h000);
        px("f1_nub", 1, 266, 13, 12'hFFF);
        px("f1_gap", 1, 4, 21, 12'h000);
        px("f1_xr127", 1, 133, 21, 12'h0F0);
        px("f1_xr128", 1, 134, 21, 12'h222);
        go(1, 0, 25);
        bat_ctl = 5'd3;
        px("f1_isolated", 1, 133, 30, 12'h0F0);

        // frames 2/3: level 3, blink toggles each frame
        px("f2_edge_white", 2, 2, 1, 12'hFFF);
        px("f2_blink_off", 2, 29, 21, 12'h222);
        px("f3_xr23_red", 3, 29, 21, 12'hF00);
        px("f3_xr24", 3, 30, 21, 12'h222);
        go(3, 0, 30);
        bat_ctl = 5'd15;

        // frame 4: level 15, yellow regardless of blink
        px("f4_xr119_yel", 4, 125, 21, 12'hFF0);
        px("f4_xr120", 4, 126, 21, 12'h222);
        go(4, 0, 30);
        bat_ctl = 5'd31;

        // frame 5: level 31, then reset mid-frame
        px("f5_xr247", 5, 253, 21, 12'h0F0);
        px("f5_xr248", 5, 254, 21, 12'h222);
        px("f5_pre_rst", 5, 100, 30, 12'h0F0);
        rst = 1'b1;
        @(posedge clk1);
        #1;
        reset_vals("midrst");
        rst = 1'b0;
        restart_timing("rs");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
